// File: rtl/adder_sum_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared types and constants for the multi-operand sum scheduler:
//             FSM state encoding, default geometry, sum-width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_OPS = 4;

    // Width that holds N operands of W bits each without wrapping.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_sum_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sum_sched_if
//  Purpose  : Operand input and sum output handshakes of the sum scheduler.
//  Ports    : in_data/in_valid/in_ready  - operand stream (source -> block)
//             out_sum/out_ovf/out_valid/out_ready - result stream
//             busy - block is mid-operation
//  Modports : slave  - the scheduler
//             master - the environment driving operands and taking results
//  Revision : 1.0  initial release
// ============================================================================
interface adder_sum_sched_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OPS = DEF_N_OPS
) ();
    localparam int ACC_W = acc_width(WIDTH, N_OPS);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_ovf, out_valid, busy
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_ovf, out_valid, busy
    );
endinterface : adder_sum_sched_if
`default_nettype wire

// File: rtl/adder_sum_sched_alu.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sum_alu
//  Purpose  : Combinational unsigned adder; the single adder shared by the
//             scheduler across all operand additions.
//  Ports    : a, b (W bits) in; sum (W bits) out, a+b truncated to W bits
//  Revision : 1.0  initial release
// ============================================================================
module adder_sum_alu #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    // Operands are pre-sized by the caller so that this never wraps.
    assign sum = a + b;
endmodule : adder_sum_alu
`default_nettype wire

// File: rtl/adder_sum_sched.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sum_sched
//  Purpose  : Buffers N_OPS operands arriving on a valid/ready stream, then
//             sums them over N_OPS-1 cycles with one shared adder and offers
//             the widened sum on a valid/ready output stream.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous active-high reset
//             bus   - slave side of adder_sum_sched_if (operands, result, busy)
//  Revision : 1.0  initial release
// ============================================================================
module adder_sum_sched
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OPS = DEF_N_OPS
) (
    input  logic              clk,
    input  logic              reset,
    adder_sum_sched_if.slave  bus
);
    localparam int ACC_W = acc_width(WIDTH, N_OPS);
    localparam int IDX_W = $clog2(N_OPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [IDX_W-1:0]      i_q,     i_d;
    logic [ACC_W-1:0]      acc_q,   acc_d;
    logic [WIDTH-1:0]      op_q [N_OPS];
    logic [WIDTH-1:0]      op_d [N_OPS];

    logic [ACC_W-1:0]      alu_b;
    logic [ACC_W-1:0]      alu_sum;

    // The one and only adder; acc is always the left operand.
    adder_sum_alu #(.W(ACC_W)) u_alu (
        .a   (acc_q),
        .b   (alu_b),
        .sum (alu_sum)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_d     = i_q;
        acc_d   = acc_q;
        op_d    = op_q;
        alu_b   = {{(ACC_W-WIDTH){1'b0}}, op_q[i_q]};

        case (state_q)
            LOAD: begin
                // in_ready is 1 throughout LOAD, so in_valid alone is a transfer.
                if (bus.in_valid) begin
                    op_d[idx_q] = bus.in_data;
                    idx_d       = idx_q + IDX_W'(1);
                    // Operand 0 seeds acc directly, saving one add cycle.
                    if (idx_q == '0) begin
                        acc_d = {{(ACC_W-WIDTH){1'b0}}, bus.in_data};
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ACCUM;
                        i_d     = IDX_W'(1);
                    end
                end
            end
            ACCUM: begin
                acc_d = alu_sum;
                i_d   = i_q + IDX_W'(1);
                if (i_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            idx_q   <= '0;
            i_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
        end
    end

    // Operand storage carries no reset: every slot is rewritten before use.
    always_ff @(posedge clk) begin
        op_q <= op_d;
    end

    // All handshake outputs are Moore, decoded from registered state only.
    always_comb begin
        bus.in_ready  = (state_q == LOAD);
        bus.out_valid = (state_q == DONE);
        bus.out_sum   = (state_q == DONE) ? acc_q : '0;
        bus.out_ovf   = (state_q == DONE) && (|acc_q[ACC_W-1:WIDTH]);
        bus.busy      = (state_q != LOAD) || (idx_q != '0);
    end

endmodule : adder_sum_sched
`default_nettype wire

// File: tb/tb_adder_sum_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_sum_sched
//  Purpose  : Directed self-checking bench for adder_sum_sched at defaults.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_sum_sched;
    localparam int WIDTH = 8;
    localparam int N_OPS = 4;
    localparam int ACC_W = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adder_sum_sched_if #(.WIDTH(WIDTH), .N_OPS(N_OPS)) bus ();

    adder_sum_sched #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Step until out_valid is seen or the budget runs out.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
        tests_run++;
        if (bus.out_sum !== 10'd0 || bus.out_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_sum: got %0d/%b required 0/0", bus.out_sum, bus.out_ovf);
        end
        step();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        // Now 1 ns past edge T (4th accept): valid must rise after T+3.
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL basic_busy: got %b required 1", bus.busy);
        end
        for (int k = 1; k <= 2; k++) begin
            step();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                tests_failed++; $display("FAIL basic_early_valid: T+%0d valid=%b in_ready=%b required 0/0", k, bus.out_valid, bus.in_ready);
            end
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd10 || bus.out_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL basic_sum: valid=%b sum=%0d ovf=%b required 1/10/0", bus.out_valid, bus.out_sum, bus.out_ovf);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL basic_pulse: valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_max();
        int cyc;
        bus.out_ready = 1'b1;
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        wait_valid(cyc);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'h3FC || bus.out_ovf !== 1'b1) begin
            tests_failed++; $display("FAIL max_sum: valid=%b sum=%0d ovf=%b required 1/1020/1", bus.out_valid, bus.out_sum, bus.out_ovf);
        end
        step();
        send(8'd100); send(8'd100); send(8'd50); send(8'd5);
        wait_valid(cyc);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd255 || bus.out_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL boundary_sum: valid=%b sum=%0d ovf=%b required 1/255/0", bus.out_valid, bus.out_sum, bus.out_ovf);
        end
        step();
    endtask

    task automatic test_gaps();
        int bad;
        bus.out_ready = 1'b1;
        send(8'd10);
        step(); step();
        send(8'd20);
        step();
        send(8'd30);
        send(8'd40);
        // Junk offered while the block is summing must be ignored.
        bus.in_data  = 8'd200;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.in_ready !== 1'b0) bad++;
            if (bus.out_valid === 1'b1) break;
            step();
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL gaps_in_ready: %0d cycles with in_ready=1 required 0", bad);
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd100) begin
            tests_failed++; $display("FAIL gaps_sum: valid=%b sum=%0d required 1/100", bus.out_valid, bus.out_sum);
        end
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        bus.out_ready = 1'b0;
        send(8'd50); send(8'd60); send(8'd70); send(8'd80);
        wait_valid(cyc);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd260 ||
                bus.out_ovf !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL bp_hold: %0d unstable cycles, sum=%0d required 0 cycles sum 260", bad, bus.out_sum);
        end
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_release: valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        send(8'd7); send(8'd7); send(8'd7); send(8'd7);
        wait_valid(cyc);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd28) begin
            tests_failed++; $display("FAIL bp_next_sum: valid=%b sum=%0d required 1/28", bus.out_valid, bus.out_sum);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        bus.out_ready = 1'b1;
        send(8'd9); send(8'd9); send(8'd9); send(8'd9);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_state: valid=%b busy=%b in_ready=%b required 0/0/1", bus.out_valid, bus.busy, bus.in_ready);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.out_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL midreset_no_output: %0d cycles valid required 0", bad);
        end
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        wait_valid(cyc);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd4) begin
            tests_failed++; $display("FAIL midreset_fresh_sum: valid=%b sum=%0d required 1/4", bus.out_valid, bus.out_sum);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int t [3];
        logic [ACC_W-1:0] got [3];
        logic [WIDTH-1:0] ops [3][4];
        logic [ACC_W-1:0] exp_sum [3];
        ops[0] = '{8'd0, 8'd0, 8'd0, 8'd0};
        ops[1] = '{8'd1, 8'd0, 8'd0, 8'd0};
        ops[2] = '{8'd0, 8'd0, 8'd0, 8'd255};
        exp_sum = '{10'd0, 10'd1, 10'd255};
        bus.out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) send(ops[s][j]);
            wait_valid(cyc);
            t[s]   = cycle;
            got[s] = bus.out_valid ? bus.out_sum : 10'h3FF;
        end
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if (got[s] !== exp_sum[s]) begin
                tests_failed++; $display("FAIL b2b_sum%0d: got %0d required %0d", s, got[s], exp_sum[s]);
            end
        end
        for (int s = 1; s < 3; s++) begin
            tests_run++;
            if (t[s] - t[s-1] != 8) begin
                tests_failed++; $display("FAIL b2b_period%0d: got %0d cycles required 8", s, t[s] - t[s-1]);
            end
        end
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_max();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_adder_sum_sched
`default_nettype wire

// File: doc/adder_sum_sched.md
Name: adder_sum_sched

Overview:
Multi-operand sum scheduler that time-shares one adder across N_OPS operands.
- Operands arrive serially on a valid/ready input port and are buffered in an internal operand register file.
- The block then sequences the single shared adder for N_OPS-1 cycles and presents the widened sum on a valid/ready output port.
- It sits between the ui_in/uo_out pin logic and the adder datapath in the top-level tile. It replaces parallel per-operand adders with one sequenced adder.

Parameters:
- WIDTH, 8, operand width in bits.
- N_OPS, 4, operands per sum; legal range 2..8.
- ACC_W, WIDTH+$clog2(N_OPS), derived sum width (10 at defaults); localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  operand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts an operand this cycle.
- out_sum  output  ACC_W  full-width sum.
- out_ovf  output  1  sum exceeds 2^WIDTH-1.
- out_valid  output  1  out_sum/out_ovf valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  state is not LOAD, or idx != 0.

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: state=LOAD, idx=0, acc=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, in_ready=1 (Moore, from state). Operand registers are don't-care after reset.
- Transfers occur on rising clk when valid&&ready. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- State LOAD:
  - in_ready=1.
  - On accept: op[idx]<=in_data and idx<=idx+1. When idx==0, acc<=zero-extended in_data.
  - Accepting with idx==N_OPS-1 moves to ACCUM, with i<=1.
  - Gaps in in_valid simply stall. There is no timeout.
- State ACCUM:
  - in_ready=0.
  - Each cycle the shared adder computes acc+op[i] at ACC_W width and acc<=sum.
  - i increments each cycle. After the add with i==N_OPS-1, go to DONE.
  - Exactly N_OPS-1 cycles. The adder is used nowhere else.
- State DONE:
  - out_valid=1, out_sum=acc, out_ovf=|acc[ACC_W-1:WIDTH].
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: go to LOAD, idx<=0, out_valid<=0.
  - in_ready stays 0 during DONE, so it is not possible to accept and emit in the same cycle.
- Latency: with the last operand accepted at edge T, out_valid rises after edge T+N_OPS-1 (T+3 at defaults). Throughput is one sum per 2*N_OPS cycles minimum (N_OPS load + N_OPS-1 accum + 1 drain).
- Arithmetic: unsigned only. ACC_W guarantees no wrap; the maximum is N_OPS*(2^WIDTH-1) = 1020 at defaults.
- reset asserted in any state, including mid-LOAD or mid-ACCUM, aborts the operation on the next edge. Partial operands are discarded and there is no output.
- reset has priority over every handshake in the same cycle.
- in_valid asserted while in_ready=0 is ignored. Data need not be held by the source, but a compliant source holds it.

Decomposition:
- Package adder_pkg:
  - state enum {LOAD, ACCUM, DONE} (2-bit).
  - default WIDTH, N_OPS constants.
  - function computing ACC_W.
- Sub-module adder_sum_alu: combinational ACC_W-bit unsigned adder (a, b -> sum). It is the single shared resource, instantiated once.
- adder_sum_sched holds the FSM, counters idx/i, the operand register file and acc.

Test Plan:
- Basic sum: feed 1,2,3,4 back-to-back with out_ready=1 -> out_sum=10, out_ovf=0. out_valid pulses exactly 1 cycle, 3 edges after the 4th accept.
- Maximum values: feed 255,255,255,255 -> out_sum=1020 (0x3FC), out_ovf=1. Also feed 100,100,50,5 -> 255, out_ovf=0 (boundary).
- Input gaps: feed 10,_,_,20,_,30,40 with in_valid low in the gaps -> out_sum=100. Check in_ready=0 throughout ACCUM/DONE and that ignored in_valid pulses in ACCUM do not alter the result.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0. After release, the next operand set 7,7,7,7 -> 28.
- Reset mid-operation: assert reset for 1 cycle during ACCUM, after operands 9,9,9,9 -> no out_valid, busy=0, in_ready=1 next cycle. A fresh 1,1,1,1 -> 4 (no stale acc).
- Back-to-back sums: three consecutive operand sets (0,0,0,0), (1,0,0,0), (0,0,0,255) -> 0, 1, 255 in order. Measured period is 8 cycles each with always-ready source and sink.
